// File: rtl/gate_sweep_ctrl.sv
//==============================================================================
// gate_sweep_ctrl : exhaustive truth-table sweep of an N-input, 1-output gate
// Revision 1.0 - initial release
//==============================================================================
`default_nettype none

module gate_sweep_ctrl #(
   parameter int                   N_IN   = 4,
   parameter int                   SETTLE = 2,
   parameter logic [(1<<N_IN)-1:0] EXPECT = 16'h8000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] vec,
   input  logic            dut_s,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic            fail_vld,
   output logic [N_IN-1:0] fail_idx
);

   localparam int            WW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [WW-1:0] LAST_WAIT = WW'(SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [N_IN-1:0] idx;
   logic [WW-1:0]   wait_cnt;
   logic            pass_r;
   logic            last_idx;
   logic            mismatch;

   assign last_idx = &idx;
   assign mismatch = (dut_s != EXPECT[idx]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = APPLY;
         APPLY:   if (wait_cnt == LAST_WAIT) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = last_idx ? DONE : APPLY;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         wait_cnt  <= '0;
         err_count <= '0;
         fail_vld  <= 1'b0;
         fail_idx  <= '0;
         pass_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx       <= '0;
                  wait_cnt  <= '0;
                  err_count <= '0;
                  fail_vld  <= 1'b0;
                  fail_idx  <= '0;
                  pass_r    <= 1'b0;
               end
            end
            APPLY: begin
               wait_cnt <= wait_cnt + WW'(1);
            end
            SAMPLE: begin
               if (mismatch) begin
                  err_count <= err_count + (N_IN+1)'(1);
                  if (!fail_vld) begin
                     fail_idx <= idx;
                     fail_vld <= 1'b1;
                  end
               end
               // idx stops on the last vector so vec can hold it through DONE
               if (!last_idx) begin
                  idx <= idx + N_IN'(1);
               end
               wait_cnt <= '0;
            end
            DONE: begin
               pass_r <= (err_count == '0);
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign vec  = (state == IDLE) ? '0 : idx;
   // verdict is already visible during the DONE cycle, then held by pass_r
   assign pass = (state == DONE) ? (err_count == '0) : pass_r;

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
//==============================================================================
// tb_gate_sweep_ctrl : directed self-checking bench for gate_sweep_ctrl
// Revision 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_gate_sweep_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] vec;
   logic       dut_s;
   logic       busy;
   logic       done;
   logic       pass;
   logic [4:0] err_count;
   logic       fail_vld;
   logic [3:0] fail_idx;

   logic       start1;
   logic [3:0] vec1;
   logic       dut_s1;
   logic       busy1;
   logic       done1;
   logic       pass1;
   logic [4:0] err_count1;
   logic       fail_vld1;
   logic [3:0] fail_idx1;

   int         mode;
   int         checks;
   int         errors;

   gate_sweep_ctrl u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .vec       (vec),
      .dut_s     (dut_s),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_vld  (fail_vld),
      .fail_idx  (fail_idx)
   );

   gate_sweep_ctrl #(.N_IN(4), .SETTLE(1), .EXPECT(16'h8000)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start1),
      .vec       (vec1),
      .dut_s     (dut_s1),
      .busy      (busy1),
      .done      (done1),
      .pass      (pass1),
      .err_count (err_count1),
      .fail_vld  (fail_vld1),
      .fail_idx  (fail_idx1)
   );

   // gate under test: 0=AND4, 1=stuck-at-0, 2=NAND4, 3=AND4 with vector 5 forced high
   always_comb begin
      dut_s = &vec;
      case (mode)
         1:       dut_s = 1'b0;
         2:       dut_s = ~(&vec);
         3:       dut_s = (&vec) | (vec == 4'd5);
         default: dut_s = &vec;
      endcase
   end
   assign dut_s1 = &vec1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full sweep on the SETTLE=2 instance; cycle n counts from 1 after the start edge.
   task automatic sweep(input string tag, input int exp_errs, input int exp_fidx,
                        input int exp_fvld, input int exp_pass, input int repulse);
      int done_at;
      int done_cnt;
      int vec_bad;
      done_at  = 0;
      done_cnt = 0;
      vec_bad  = 0;
      start    = 1'b1;
      step();
      for (int n = 1; n <= 52; n++) begin
         start = (n == repulse) ? 1'b1 : 1'b0;
         if (done) begin
            done_cnt++;
            if (done_at == 0) begin
               done_at = n;
               chk({tag, "_pass_in_done"}, 32'(pass), 32'(exp_pass));
               chk({tag, "_vec_in_done"}, 32'(vec), 32'd15);
            end
         end
         if (n <= 48 && (vec !== 4'((n - 1) / 3) || busy !== 1'b1)) vec_bad++;
         step();
      end
      start = 1'b0;
      chk({tag, "_vec_seq_bad"}, 32'(vec_bad), 32'd0);
      chk({tag, "_done_cycle"}, 32'(done_at), 32'd49);
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({tag, "_vec_after"}, 32'(vec), 32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'(exp_errs));
      chk({tag, "_fail_vld"}, 32'(fail_vld), 32'(exp_fvld));
      chk({tag, "_fail_idx"}, 32'(fail_idx), 32'(exp_fidx));
      chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
   endtask

   initial begin
      int done_at1;
      checks = 0;
      errors = 0;
      mode   = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      start1 = 1'b0;
      step();
      step();
      chk("rst_vec", 32'(vec), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);
      chk("rst_fvld", 32'(fail_vld), 32'd0);
      chk("rst_fidx", 32'(fail_idx), 32'd0);
      rst_n = 1'b1;
      step();
      chk("idle_busy", 32'(busy), 32'd0);

      mode = 0; sweep("and4", 0, 0, 0, 1, 0);
      step();
      chk("and4_pass_held", 32'(pass), 32'd1);
      mode = 1; sweep("stuck0", 1, 15, 1, 0, 0);
      mode = 2; sweep("nand4", 16, 0, 1, 0, 0);
      mode = 3; sweep("bit5", 1, 5, 1, 0, 0);
      mode = 0; sweep("repulse", 0, 0, 0, 1, 10);

      // Reset during vector 7 of a NAND sweep: 7 mismatches are live, then cleared at once
      mode  = 2;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n < 22; n++) step();
      chk("mid_vec7", 32'(vec), 32'd7);
      chk("mid_err7", 32'(err_count), 32'd7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_vec", 32'(vec), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_err", 32'(err_count), 32'd0);
      chk("async_fvld", 32'(fail_vld), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      mode = 0; sweep("fresh", 0, 0, 0, 1, 0);

      // SETTLE=1 instance: done expected 33 cycles after the start edge
      done_at1 = 0;
      start1   = 1'b1;
      step();
      start1 = 1'b0;
      for (int n = 1; n <= 36; n++) begin
         if (done1 && done_at1 == 0) done_at1 = n;
         step();
      end
      chk("s1_done_cycle", 32'(done_at1), 32'd33);
      chk("s1_pass", 32'(pass1), 32'd1);
      chk("s1_err", 32'(err_count1), 32'd0);
      chk("s1_busy", 32'(busy1), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
